// File: rtl/item_selector.sv
// Button/auto-scroll driven selector producing the 3-bit item code for the HEX name decoder.
// Steps a ring of six valid codes and latches a chosen item on select.
module item_selector #(
    parameter int unsigned SCROLL_TICKS = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       next_btn,
    input  logic       prev_btn,
    input  logic       sel_btn,
    input  logic       auto_en,
    output logic [2:0] item_code,
    output logic [2:0] item_idx,
    output logic [2:0] chosen_code,
    output logic       chosen_valid
);

    typedef enum logic {
        IDLE,
        SCROLL
    } mode_e;

    localparam int unsigned CW = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCROLL_TICKS - 1);

    // bit 0 = next, bit 1 = prev, bit 2 = sel
    logic [2:0] s1, s2, s3;
    logic [2:0] ev;
    logic       ev_next, ev_prev, ev_sel;

    mode_e         mode;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    idx_d;
    logic          auto_adv, fwd, back;

    function automatic logic [2:0] idx_to_code(input logic [2:0] idx);
        logic [2:0] code;
        case (idx)
            3'd0:    code = 3'b000;
            3'd1:    code = 3'b001;
            3'd2:    code = 3'b010;
            3'd3:    code = 3'b100;
            3'd4:    code = 3'b101;
            3'd5:    code = 3'b111;
            default: code = 3'b000;
        endcase
        return code;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= {sel_btn, prev_btn, next_btn};
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign ev      = s2 & ~s3;
    assign ev_next = ev[0];
    assign ev_prev = ev[1];
    assign ev_sel  = ev[2];

    // auto_en is a slow switch, so it selects the mode directly without synchronizing
    always_comb begin
        mode     = auto_en ? SCROLL : IDLE;
        cnt_d    = cnt;
        auto_adv = 1'b0;
        case (mode)
            IDLE: cnt_d = '0;
            SCROLL: begin
                if (ev_next || ev_prev) begin
                    cnt_d = '0;
                end else if (cnt == LAST) begin
                    cnt_d    = '0;
                    auto_adv = 1'b1;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: cnt_d = '0;
        endcase

        fwd   = (ev_next && !ev_prev) || auto_adv;
        back  = ev_prev && !ev_next;
        idx_d = item_idx;
        if (fwd) begin
            idx_d = (item_idx == 3'd5) ? 3'd0 : item_idx + 3'd1;
        end else if (back) begin
            idx_d = (item_idx == 3'd0) ? 3'd5 : item_idx - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            item_idx     <= '0;
            item_code    <= '0;
            chosen_code  <= '0;
            chosen_valid <= 1'b0;
        end else begin
            cnt       <= cnt_d;
            item_idx  <= idx_d;
            item_code <= idx_to_code(idx_d);
            if (ev_sel) begin
                chosen_code  <= item_code;
                chosen_valid <= 1'b1;
            end
        end
    end

endmodule
